// File: rtl/sd_pkg.sv
// Shared sizing constants and types for the sd_demodulator sinc3 decimator.
package sd_pkg;

   localparam int SD_DEC_MIN   = 3;
   localparam int SD_CIC_ORDER = 3;

   // Order-N growth for R = 2^dec_bits, plus one bit so the full-scale value R^N itself fits.
   function automatic int sd_acc_w(input int dec_bits);
      return SD_CIC_ORDER * dec_bits + 1;
   endfunction

   localparam int SD_ACC_W_DEF = sd_acc_w(9);

   typedef logic [SD_ACC_W_DEF-1:0] sd_acc_t;

endpackage

// File: rtl/sd_demodulator_if.sv
// Bitstream-in / PCM-out bundle of sd_demodulator; slave side is the demodulator.
interface sd_demodulator_if #(
   parameter int pBITS = 24
);
   logic                    iCE;
   logic                    iSD;
   logic signed [pBITS-1:0] oDATA;
   logic                    oSTROBE;
   logic                    oCLIP;

   modport master (output iCE, iSD, input oDATA, oSTROBE, oCLIP);
   modport slave  (input iCE, iSD, output oDATA, oSTROBE, oCLIP);
endinterface

// File: rtl/sd_cic_comb.sv
// One CIC comb stage: o_data = i_data - previous i_data, advancing only when i_vld is high.
module sd_cic_comb
   import sd_pkg::*;
#(
   parameter int W = sd_acc_w(9)
) (
   input  logic         iCLK,
   input  logic         iRESET,
   input  logic         i_vld,
   input  logic [W-1:0] i_data,
   output logic         o_vld,
   output logic [W-1:0] o_data
);

   logic [W-1:0] r_prev_p0;
   logic [W-1:0] r_data_p1;
   logic         r_vld_p1;

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_prev_p0 <= '0;
         r_data_p1 <= '0;
         r_vld_p1  <= 1'b0;
      end else begin
         r_vld_p1 <= i_vld;
         if (i_vld) begin
            r_data_p1 <= i_data - r_prev_p0;
            r_prev_p0 <= i_data;
         end
      end
   end

   assign o_vld  = r_vld_p1;
   assign o_data = r_data_p1;

endmodule

// File: rtl/sd_demodulator.sv
// Sinc3 CIC decimator turning a 1-bit sigma-delta stream into signed PCM, decimating by 2^pDEC_BITS.
// Optional macro SD_DEMOD_SETTLE_EN suppresses the two partial-window outputs after reset.
module sd_demodulator
   import sd_pkg::*;
#(
   parameter int pBITS     = 24,
   parameter int pDEC_BITS = 9
) (
   input  logic            iCLK,
   input  logic            iRESET,
   sd_demodulator_if.slave bus
);

   localparam int W  = sd_acc_w(pDEC_BITS);
   localparam int N3 = SD_CIC_ORDER * pDEC_BITS;

   if (pDEC_BITS < SD_DEC_MIN) begin : g_chk_dec
      $error("sd_demodulator: pDEC_BITS below minimum");
   end
   if (pBITS > N3) begin : g_chk_bits
      $error("sd_demodulator: pBITS exceeds 3*pDEC_BITS");
   end

   // y == R^3 only for a full-scale run of ones; that single code cannot be represented after the offset.
   function automatic logic f_is_clip(input logic [W-1:0] y);
      return y == (W'(1) << N3);
   endfunction

   function automatic logic [pBITS-1:0] f_to_pcm(input logic [W-1:0] y);
      logic [N3-1:0] s;
      if (f_is_clip(y)) s = {1'b0, {(N3-1){1'b1}}};
      else              s = {~y[N3-1], y[N3-2:0]};
      return s[N3-1 -: pBITS];
   endfunction

   logic [W-1:0]         r_i1, r_i2, r_i3;
   logic [pDEC_BITS-1:0] r_cnt;
   logic [W-1:0]         r_d0_p0;
   logic                 r_vld_p0;
   logic [W-1:0]         w_x;
   logic [W-1:0]         w_i3_next;
   logic                 w_tick;

   assign w_x       = {{(W-1){1'b0}}, bus.iSD};
   assign w_i3_next = r_i3 + r_i2;
   assign w_tick    = bus.iCE && (r_cnt == {pDEC_BITS{1'b1}});

   // Stage p0: integrators at the input rate, decimated sample latched on the tick
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_i1     <= '0;
         r_i2     <= '0;
         r_i3     <= '0;
         r_cnt    <= '0;
         r_d0_p0  <= '0;
         r_vld_p0 <= 1'b0;
      end else begin
         r_vld_p0 <= w_tick;
         if (bus.iCE) begin
            r_i1  <= r_i1 + w_x;
            r_i2  <= r_i2 + r_i1;
            r_i3  <= w_i3_next;
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_tick) r_d0_p0 <= w_i3_next;
      end
   end

   logic         w_c1_vld, w_c2_vld, w_c3_vld;
   logic [W-1:0] w_c1, w_c2, w_c3;

   // Stages p1..p3: comb chain at the decimated rate
   sd_cic_comb #(.W(W)) u_comb1 (
      .iCLK(iCLK), .iRESET(iRESET), .i_vld(r_vld_p0), .i_data(r_d0_p0),
      .o_vld(w_c1_vld), .o_data(w_c1)
   );
   sd_cic_comb #(.W(W)) u_comb2 (
      .iCLK(iCLK), .iRESET(iRESET), .i_vld(w_c1_vld), .i_data(w_c1),
      .o_vld(w_c2_vld), .o_data(w_c2)
   );
   sd_cic_comb #(.W(W)) u_comb3 (
      .iCLK(iCLK), .iRESET(iRESET), .i_vld(w_c2_vld), .i_data(w_c2),
      .o_vld(w_c3_vld), .o_data(w_c3)
   );

   logic w_emit;

`ifdef SD_DEMOD_SETTLE_EN
   logic [1:0] r_settle;

   always_ff @(posedge iCLK) begin
      if (iRESET)                             r_settle <= 2'd0;
      else if (w_c3_vld && r_settle != 2'd2) r_settle <= r_settle + 2'd1;
   end

   assign w_emit = w_c3_vld && (r_settle == 2'd2);
`else
   assign w_emit = w_c3_vld;
`endif

   logic [pBITS-1:0] r_data_p4;
   logic             r_clip_p4;
   logic             r_stb_p4;

   // Stage p4: offset, saturate, truncate and strobe
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_data_p4 <= '0;
         r_clip_p4 <= 1'b0;
         r_stb_p4  <= 1'b0;
      end else begin
         r_stb_p4 <= w_emit;
         if (w_emit) begin
            r_data_p4 <= f_to_pcm(w_c3);
            r_clip_p4 <= f_is_clip(w_c3);
         end
      end
   end

   assign bus.oDATA   = r_data_p4;
   assign bus.oCLIP   = r_clip_p4;
   assign bus.oSTROBE = r_stb_p4;

endmodule
